avst_frame_tx: RTL and testbench

// - Store-and-forward Avalon-ST frame transmitter feeding a TSE MAC transmit port (tse_N_transmit_*).
// - Collects one complete frame from the internal word-write interface, then streams it as sop/eop/empty beats under ready/valid.
// - Sits between the internal packet logic and the MAC transmit sink; the transmit counterpart to the receive path.

---
 rtl/avst_frame_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_avst_frame_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_frame_tx.sv
// avst_frame_tx: store-and-forward Avalon-ST frame transmitter for a TSE MAC
// transmit sink. One complete frame is collected from the word-write side and
// then streamed out as sop/eop/empty beats under ready/valid.
// Optional build macro AVST_TX_PAD_EN: short frames are zero-padded to MIN_WORDS.
module avst_frame_tx #(
  parameter int unsigned DEPTH     = 384,
  parameter int unsigned MIN_WORDS = 15
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic        wr_last,
  input  logic [1:0]  wr_empty,
  output logic        wr_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [1:0]  out_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int unsigned AW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [31:0]   mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] tx_len_q, tx_len_d;
  logic [1:0]    empty_q, empty_d;
  logic          pad_q, pad_d;
  logic          wr_ready_q, wr_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [1:0]    out_empty_q, out_empty_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic          wr_hs, tx_hs, mem_we, load_first;
  logic [AW-1:0] fl_len, fl_tx_len;
  logic          fl_pad, fl_eop;
  logic [31:0]   fl_raw, fl_word;
  logic [AW-1:0] nx_idx;
  logic [31:0]   nx_raw, nx_word;
  logic          nx_eop;
  logic [1:0]    nx_empty;

  // Clears the unused low-order bytes of a frame's final word.
  function automatic logic [31:0] mask_tail(input logic [31:0] w, input logic [1:0] e);
    case (e)
      2'd1:    mask_tail = {w[31:8], 8'h00};
      2'd2:    mask_tail = {w[31:16], 16'h0000};
      2'd3:    mask_tail = {w[31:24], 24'h000000};
      default: mask_tail = w;
    endcase
  endfunction

  assign wr_hs  = wr_valid & wr_ready_q;
  assign tx_hs  = out_valid_q & out_ready;
  assign mem_we = wr_hs & ((state_q == S_IDLE) | (state_q == S_FILL)) & (wr_ptr_q < AW'(DEPTH));

  // First beat is formed at the wr_last handshake; a one-word frame bypasses the buffer.
  always_comb begin
    fl_len = wr_ptr_q + AW'(1);
`ifdef AVST_TX_PAD_EN
    fl_pad = ((32'(fl_len) * 32'd4) - 32'(wr_empty)) < 32'(MIN_WORDS * 4);
`else
    fl_pad = 1'b0;
`endif
    fl_tx_len = fl_pad ? AW'(MIN_WORDS) : fl_len;
    fl_raw    = (wr_ptr_q == '0) ? wr_data : mem_q[0];
    fl_word   = (fl_pad && (fl_len == AW'(1))) ? mask_tail(fl_raw, wr_empty) : fl_raw;
    fl_eop    = (fl_tx_len == AW'(1));
  end

  // Beat following the one currently presented; words past the stored length are padding zeros.
  always_comb begin
    nx_idx   = rd_ptr_q + AW'(1);
    nx_raw   = (nx_idx < len_q) ? mem_q[nx_idx[IW-1:0]] : '0;
    nx_word  = (pad_q && (nx_idx == len_q - AW'(1))) ? mask_tail(nx_raw, empty_q) : nx_raw;
    nx_eop   = (nx_idx == tx_len_q - AW'(1));
    nx_empty = (nx_eop && !pad_q) ? empty_q : 2'd0;
  end

  // Frame FSM: fill, overflow discard, and output beat sequencing.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    len_d         = len_q;
    tx_len_d      = tx_len_q;
    empty_d       = empty_q;
    pad_d         = pad_q;
    out_valid_d   = out_valid_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_data_d    = out_data_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    load_first    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_hs) begin
          if (wr_last) load_first = 1'b1;
          else begin
            state_d  = S_FILL;
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      S_FILL: begin
        if (wr_hs) begin
          if (wr_ptr_q == AW'(DEPTH)) begin
            drop_count_d = drop_count_q + 16'd1;
            if (wr_last) begin
              state_d  = S_IDLE;
              wr_ptr_d = '0;
            end else begin
              state_d = S_DISCARD;
            end
          end else if (wr_last) begin
            load_first = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      S_DISCARD: begin
        if (wr_hs && wr_last) begin
          state_d  = S_IDLE;
          wr_ptr_d = '0;
        end
      end
      S_SEND: begin
        if (tx_hs) begin
          if (out_eop_q) begin
            state_d       = S_IDLE;
            wr_ptr_d      = '0;
            out_valid_d   = 1'b0;
            out_sop_d     = 1'b0;
            out_eop_d     = 1'b0;
            out_empty_d   = 2'd0;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            rd_ptr_d    = nx_idx;
            out_data_d  = nx_word;
            out_sop_d   = 1'b0;
            out_eop_d   = nx_eop;
            out_empty_d = nx_empty;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_first) begin
      state_d     = S_SEND;
      len_d       = fl_len;
      tx_len_d    = fl_tx_len;
      empty_d     = wr_empty;
      pad_d       = fl_pad;
      rd_ptr_d    = '0;
      out_valid_d = 1'b1;
      out_data_d  = fl_word;
      out_sop_d   = 1'b1;
      out_eop_d   = fl_eop;
      out_empty_d = (fl_eop && !fl_pad) ? wr_empty : 2'd0;
    end
    wr_ready_d = (state_d != S_SEND);
  end

  // Frame buffer write port.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[wr_ptr_q[IW-1:0]] <= wr_data;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      len_q         <= '0;
      tx_len_q      <= '0;
      empty_q       <= '0;
      pad_q         <= 1'b0;
      wr_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_data_q    <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      len_q         <= len_d;
      tx_len_q      <= tx_len_d;
      empty_q       <= empty_d;
      pad_q         <= pad_d;
      wr_ready_q    <= wr_ready_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_data_q    <= out_data_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign out_data    = out_data_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_empty   = out_empty_q;
  assign out_valid   = out_valid_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_avst_frame_tx.sv
// Bench for avst_frame_tx: table of frames with hand-computed results,
// plus hand-written single-word, overflow and mid-frame reset sequences.
module tb_avst_frame_tx;
  localparam int DEPTH = 384;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic [1:0]  wr_empty = '0;
  logic        wr_ready;
  logic [31:0] out_data;
  logic        out_sop, out_eop, out_valid;
  logic [1:0]  out_empty;
  logic        out_ready = 1'b1;
  logic [15:0] frame_count, drop_count;

  always #5 sys_clk = ~sys_clk;

  avst_frame_tx #(.DEPTH(DEPTH), .MIN_WORDS(15)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_empty(wr_empty),
    .wr_ready(wr_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  typedef struct {
    int          n;
    logic [7:0]  seed;
    logic [1:0]  e;
    bit          toggle;
    int          exp_beats;
    int          exp_vcyc;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [1:0]  exp_lempty;
  } row_t;

  typedef struct {
    int          beats;
    int          vcyc;
    logic [31:0] first;
    logic [31:0] last;
    logic [1:0]  lempty;
    int          bad_data;
    int          bad_sop;
    int          bad_stall;
    bit          timeout;
  } rx_t;

  int n_pass = 0;
  int n_total = 0;
  int exp_fc = 0;
  int ov_seen = 0;
  int wr_to = 0;
  int wr_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] gen(input logic [7:0] seed, input int k);
    logic [7:0] b;
    b = seed + 8'(4 * k);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  function automatic bit padded(input int n, input logic [1:0] e);
`ifdef AVST_TX_PAD_EN
    return (4 * n - int'(e)) < 60;
`else
    return (n < 0) && (e == 2'd0);
`endif
  endfunction

  function automatic int model_beats(input int n, input logic [1:0] e);
    return padded(n, e) ? 15 : n;
  endfunction

  function automatic logic [31:0] model_word(input logic [7:0] seed, input int n, input logic [1:0] e, input int k);
    logic [31:0] w;
    if (k >= n) return 32'h0;
    w = gen(seed, k);
    if (padded(n, e) && k == n - 1) w = w & (32'hFFFF_FFFF << (8 * int'(e)));
    return w;
  endfunction

  function automatic logic [1:0] model_empty(input int n, input logic [1:0] e, input int k);
    if (k != model_beats(n, e) - 1) return 2'd0;
    return padded(n, e) ? 2'd0 : e;
  endfunction

  task automatic wr_word(input logic [31:0] d, input bit last, input logic [1:0] e);
    bit hs;
    bit ok;
    ok = 1'b0;
    wr_valid = 1'b1; wr_data = d; wr_last = last; wr_empty = e;
    for (int c = 0; c < 200 && !ok; c++) begin
      hs = wr_ready;
      ov_seen += out_valid ? 1 : 0;
      @(posedge sys_clk); #1;
      wr_cycles++;
      if (hs) ok = 1'b1;
    end
    if (!ok) wr_to++;
    wr_valid = 1'b0; wr_last = 1'b0; wr_empty = 2'd0;
  endtask

  task automatic write_frame(input logic [7:0] seed, input int n, input logic [1:0] e);
    for (int k = 0; k < n; k++)
      wr_word(gen(seed, k), k == n - 1, (k == n - 1) ? e : 2'd0);
  endtask

  task automatic recv(input bit toggle, input bit use_model, input logic [7:0] seed,
                      input int n, input logic [1:0] e, output rx_t r);
    logic [35:0] prev;
    bit prev_stall;
    bit done;
    r.beats = 0; r.vcyc = 0; r.first = '0; r.last = '0; r.lempty = '0;
    r.bad_data = 0; r.bad_sop = 0; r.bad_stall = 0; r.timeout = 1'b0;
    prev = '0; prev_stall = 1'b0; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      out_ready = toggle ? (r.vcyc % 2 == 0) : 1'b1;
      if (out_valid) begin
        if (prev_stall && ({out_data, out_sop, out_eop, out_empty} !== prev)) r.bad_stall++;
        r.vcyc++;
        if (out_ready) begin
          if (r.beats == 0) r.first = out_data;
          r.last = out_data;
          r.lempty = out_empty;
          if (out_sop !== (r.beats == 0)) r.bad_sop++;
          if (use_model && ((out_data !== model_word(seed, n, e, r.beats)) ||
                            (out_eop !== (r.beats == model_beats(n, e) - 1)) ||
                            (out_empty !== model_empty(n, e, r.beats)))) r.bad_data++;
          r.beats++;
          if (out_eop) done = 1'b1;
        end
        prev_stall = !out_ready;
        prev = {out_data, out_sop, out_eop, out_empty};
      end else begin
        if (r.beats > 0) r.bad_stall++;
        prev_stall = 1'b0;
      end
      @(posedge sys_clk); #1;
    end
    r.timeout = !done;
    out_ready = 1'b1;
  endtask

  task automatic run_row(input string tag, input row_t R);
    rx_t r;
    wr_to = 0;
    write_frame(R.seed, R.n, R.e);
    chk({tag, "_wr_timeout"}, wr_to, 0);
    chk({tag, "_valid_rise"}, 32'(out_valid), 1);
    chk({tag, "_wr_ready_send"}, 32'(wr_ready), 0);
    recv(R.toggle, 1'b1, R.seed, R.n, R.e, r);
    chk({tag, "_timeout"}, 32'(r.timeout), 0);
    chk({tag, "_beats"}, r.beats, R.exp_beats);
    chk({tag, "_valid_cycles"}, r.vcyc, R.exp_vcyc);
    chk({tag, "_first"}, r.first, R.exp_first);
    chk({tag, "_last"}, r.last, R.exp_last);
    chk({tag, "_last_empty"}, 32'(r.lempty), 32'(R.exp_lempty));
    chk({tag, "_beat_model"}, r.bad_data, 0);
    chk({tag, "_sop"}, r.bad_sop, 0);
    chk({tag, "_stall_stable"}, r.bad_stall, 0);
    exp_fc++;
    chk({tag, "_frame_count"}, 32'(frame_count), exp_fc);
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
    chk({tag, "_idle_wr_ready"}, 32'(wr_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[6];
    row_t rr;
    rx_t  r;

    rows[0] = '{16, 8'h00, 2'd2, 1'b0, 16, 16, 32'h00010203, 32'h3C3D3E3F, 2'd2};
    rows[1] = '{16, 8'h00, 2'd2, 1'b1, 16, 31, 32'h00010203, 32'h3C3D3E3F, 2'd2};
`ifdef AVST_TX_PAD_EN
    rows[2] = '{4, 8'h10, 2'd0, 1'b0, 15, 15, 32'h10111213, 32'h00000000, 2'd0};
    rows[3] = '{15, 8'h40, 2'd1, 1'b1, 15, 29, 32'h40414243, 32'h78797A00, 2'd0};
`else
    rows[2] = '{4, 8'h10, 2'd0, 1'b0, 4, 4, 32'h10111213, 32'h1C1D1E1F, 2'd0};
    rows[3] = '{15, 8'h40, 2'd1, 1'b1, 15, 29, 32'h40414243, 32'h78797A7B, 2'd1};
`endif
    rows[4] = '{15, 8'h80, 2'd0, 1'b0, 15, 15, 32'h80818283, 32'hB8B9BABB, 2'd0};
    rows[5] = '{DEPTH, 8'h00, 2'd3, 1'b0, DEPTH, DEPTH, 32'h00010203, 32'hFCFDFEFF, 2'd3};

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_empty", 32'(out_empty), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    reset = 1'b0;
    @(posedge sys_clk); #1;
    chk("rel_wr_ready", 32'(wr_ready), 1);

    for (int i = 0; i < 6; i++) run_row($sformatf("row%0d", i), rows[i]);

    // single-word frame
    wr_to = 0;
    wr_word(32'hAABBCCDD, 1'b1, 2'd3);
    chk("sw_wr_timeout", wr_to, 0);
    recv(1'b0, 1'b0, 8'h00, 1, 2'd3, r);
    chk("sw_timeout", 32'(r.timeout), 0);
    chk("sw_sop", r.bad_sop, 0);
    chk("sw_stall", r.bad_stall, 0);
`ifdef AVST_TX_PAD_EN
    chk("sw_beats", r.beats, 15);
    chk("sw_first", r.first, 32'hAA000000);
    chk("sw_last", r.last, 32'h00000000);
    chk("sw_last_empty", 32'(r.lempty), 0);
`else
    chk("sw_beats", r.beats, 1);
    chk("sw_first", r.first, 32'hAABBCCDD);
    chk("sw_last", r.last, 32'hAABBCCDD);
    chk("sw_last_empty", 32'(r.lempty), 3);
`endif
    exp_fc++;
    chk("sw_frame_count", 32'(frame_count), exp_fc);
    chk("sw_idle_valid", 32'(out_valid), 0);

    // overflow: DEPTH+5 words, then a normal frame
    ov_seen = 0; wr_to = 0; wr_cycles = 0;
    write_frame(8'h55, DEPTH + 5, 2'd0);
    chk("ovf_wr_timeout", wr_to, 0);
    chk("ovf_cycles", wr_cycles, DEPTH + 5);
    chk("ovf_no_valid", ov_seen, 0);
    chk("ovf_valid_after", 32'(out_valid), 0);
    chk("ovf_drop_count", 32'(drop_count), 1);
    chk("ovf_wr_ready", 32'(wr_ready), 1);
    chk("ovf_frame_count", 32'(frame_count), exp_fc);
    run_row("ovf_next", rows[2]);
    chk("ovf_drop_stable", 32'(drop_count), 1);

    // reset on beat 5 of a 20-word frame
    wr_to = 0;
    write_frame(8'h20, 20, 2'd0);
    chk("mid_wr_timeout", wr_to, 0);
    out_ready = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("mid_beat5", out_data, gen(8'h20, 5));
    reset = 1'b1;
    @(posedge sys_clk); #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_frame_count", 32'(frame_count), 0);
    chk("mid_drop_count", 32'(drop_count), 0);
    reset = 1'b0;
    @(posedge sys_clk); #1;
    chk("mid_wr_ready", 32'(wr_ready), 1);
    exp_fc = 0;
`ifdef AVST_TX_PAD_EN
    rr = '{3, 8'h30, 2'd1, 1'b0, 15, 15, 32'h30313233, 32'h00000000, 2'd0};
`else
    rr = '{3, 8'h30, 2'd1, 1'b0, 3, 3, 32'h30313233, 32'h38393A3B, 2'd1};
`endif
    run_row("mid_next", rr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
